// File: rtl/ttt_pkg.sv
// Shared types and constants for the tik_tac_toe input stage.
package ttt_pkg;

  localparam int unsigned POS_W   = 4;
  localparam int unsigned POS_MAX = 8;

  typedef enum logic [1:0] {
    WAIT_P1,
    WAIT_P2,
    CHECK,
    OVER
  } state_e;

  typedef enum logic {
    P1 = 1'b0,
    P2 = 1'b1
  } player_e;

  function automatic logic pos_valid(input logic [POS_W-1:0] pos);
    return pos <= POS_W'(POS_MAX);
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchroniser, counter debouncer and one-cycle press pulse for one raw button.
module button_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_btn,
  output logic o_press
);

  localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  logic            r_s1;
  logic            r_s2;
  logic            r_db;
  logic            r_db_q;
  logic [CntW-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_s1   <= 1'b0;
      r_s2   <= 1'b0;
      r_db   <= 1'b0;
      r_db_q <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_s1   <= i_btn;
      r_s2   <= r_s1;
      r_db_q <= r_db;
      // Any sample agreeing with the debounced level restarts the run.
      if (r_s2 == r_db) begin
        r_cnt <= '0;
      end else if (r_cnt == CntLast) begin
        r_db  <= r_s2;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CntW'(1);
      end
    end
  end

  assign o_press = r_db & ~r_db_q;

endmodule

// File: rtl/move_input_ctrl.sv
// Turns debounced player buttons and the position switches into turn-ordered move strobes.
module move_input_ctrl
  import ttt_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned CHECK_CYCLES    = 2
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_btn_p1,
  input  logic             i_btn_p2,
  input  logic [POS_W-1:0] i_sw_pos,
  input  logic             i_illegal_move,
  input  logic             i_game_done,
  output logic             o_p1,
  output logic             o_p2,
  output logic [POS_W-1:0] o_p1_pos,
  output logic [POS_W-1:0] o_p2_pos,
  output logic             o_turn,
  output logic             o_rejected
);

  localparam int unsigned ChkW = (CHECK_CYCLES > 1) ? $clog2(CHECK_CYCLES) : 1;
  localparam logic [ChkW-1:0] ChkLast = ChkW'(CHECK_CYCLES - 1);

  logic w_press_p1;
  logic w_press_p2;
  logic w_press_mine;
  logic w_press_other;
  logic w_pos_ok;

  state_e           r_state;
  player_e          r_turn;
  logic [ChkW-1:0]  r_chk_cnt;
  logic [POS_W-1:0] r_pos_s1;
  logic [POS_W-1:0] r_pos_s2;
  logic             r_p1;
  logic             r_p2;
  logic [POS_W-1:0] r_p1_pos;
  logic [POS_W-1:0] r_p2_pos;
  logic             r_rejected;

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_db_p1 (
    .i_clk  (i_clk),
    .i_reset(i_reset),
    .i_btn  (i_btn_p1),
    .o_press(w_press_p1)
  );

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_db_p2 (
    .i_clk  (i_clk),
    .i_reset(i_reset),
    .i_btn  (i_btn_p2),
    .o_press(w_press_p2)
  );

  // The mover is always the player whose turn it is; turn only flips on a clean CHECK exit.
  assign w_press_mine  = (r_turn == P1) ? w_press_p1 : w_press_p2;
  assign w_press_other = (r_turn == P1) ? w_press_p2 : w_press_p1;
  assign w_pos_ok      = pos_valid(r_pos_s2);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= WAIT_P1;
      r_turn     <= P1;
      r_chk_cnt  <= '0;
      r_pos_s1   <= '0;
      r_pos_s2   <= '0;
      r_p1       <= 1'b0;
      r_p2       <= 1'b0;
      r_p1_pos   <= '0;
      r_p2_pos   <= '0;
      r_rejected <= 1'b0;
    end else begin
      r_pos_s1   <= i_sw_pos;
      r_pos_s2   <= r_pos_s1;
      r_p1       <= 1'b0;
      r_p2       <= 1'b0;
      r_rejected <= 1'b0;
      if (r_state == OVER) begin
        r_rejected <= w_press_p1 | w_press_p2;
      end else if (i_game_done) begin
        r_state    <= OVER;
        r_rejected <= w_press_p1 | w_press_p2;
      end else begin
        case (r_state)
          WAIT_P1, WAIT_P2: begin
            r_rejected <= w_press_other | (w_press_mine & ~w_pos_ok);
            if (w_press_mine && w_pos_ok) begin
              if (r_turn == P1) begin
                r_p1     <= 1'b1;
                r_p1_pos <= r_pos_s2;
              end else begin
                r_p2     <= 1'b1;
                r_p2_pos <= r_pos_s2;
              end
              r_chk_cnt <= '0;
              r_state   <= CHECK;
            end
          end
          CHECK: begin
            r_rejected <= w_press_p1 | w_press_p2;
            if (i_illegal_move) begin
              r_state <= (r_turn == P1) ? WAIT_P1 : WAIT_P2;
            end else if (r_chk_cnt == ChkLast) begin
              r_state <= (r_turn == P1) ? WAIT_P2 : WAIT_P1;
              r_turn  <= (r_turn == P1) ? P2 : P1;
            end else begin
              r_chk_cnt <= r_chk_cnt + ChkW'(1);
            end
          end
          default: r_state <= OVER;
        endcase
      end
    end
  end

  assign o_p1       = r_p1;
  assign o_p2       = r_p2;
  assign o_p1_pos   = r_p1_pos;
  assign o_p2_pos   = r_p2_pos;
  assign o_turn     = r_turn;
  assign o_rejected = r_rejected;

endmodule

// File: tb/tb_move_input_ctrl.sv
// Directed and randomized bench for move_input_ctrl against a behavioural model.
module tb_move_input_ctrl;

  localparam int unsigned D = 4;
  localparam int unsigned C = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn_p1 = 1'b0;
  logic       btn_p2 = 1'b0;
  logic [3:0] sw_pos = 4'd0;
  logic       illegal_move = 1'b0;
  logic       game_done = 1'b0;
  logic       o_p1, o_p2, o_turn, o_rejected;
  logic [3:0] o_p1_pos, o_p2_pos;

  always #5 clk = ~clk;

  move_input_ctrl #(
    .DEBOUNCE_CYCLES(D),
    .CHECK_CYCLES   (C)
  ) dut (
    .i_clk         (clk),
    .i_reset       (reset),
    .i_btn_p1      (btn_p1),
    .i_btn_p2      (btn_p2),
    .i_sw_pos      (sw_pos),
    .i_illegal_move(illegal_move),
    .i_game_done   (game_done),
    .o_p1          (o_p1),
    .o_p2          (o_p2),
    .o_p1_pos      (o_p1_pos),
    .o_p2_pos      (o_p2_pos),
    .o_turn        (o_turn),
    .o_rejected    (o_rejected)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: raw button history decides debounced levels directly.
  logic [D:0] h1 = '0, h2 = '0;  // h[k] = raw sample taken k+1 edges ago
  logic [3:0] swh0 = '0, swh1 = '0;
  bit m_db1, m_db1d, m_db2, m_db2d;
  bit m_over, m_chk, m_turn;
  int m_cc;
  bit m_p1, m_p2, m_rej;
  logic [3:0] m_p1pos = '0, m_p2pos = '0;

  always @(posedge clk) begin : model
    bit pr1, pr2, mine, other;
    logic [3:0] pos;
    if (reset) begin
      h1 = '0; h2 = '0; swh0 = '0; swh1 = '0;
      m_db1 = 0; m_db1d = 0; m_db2 = 0; m_db2d = 0;
      m_over = 0; m_chk = 0; m_turn = 0; m_cc = 0;
      m_p1 = 0; m_p2 = 0; m_rej = 0; m_p1pos = '0; m_p2pos = '0;
    end else begin
      pr1   = m_db1 && !m_db1d;
      pr2   = m_db2 && !m_db2d;
      pos   = swh1;
      mine  = m_turn ? pr2 : pr1;
      other = m_turn ? pr1 : pr2;
      m_p1 = 0; m_p2 = 0; m_rej = 0;
      if (m_over || game_done) begin
        m_rej  = pr1 || pr2;
        m_over = 1;
        m_chk  = 0;
      end else if (m_chk) begin
        m_rej = pr1 || pr2;
        if (illegal_move) m_chk = 0;
        else if (m_cc == int'(C) - 1) begin
          m_chk  = 0;
          m_turn = !m_turn;
        end else m_cc++;
      end else begin
        m_rej = other || (mine && pos > 4'd8);
        if (mine && pos <= 4'd8) begin
          if (m_turn) begin m_p2 = 1; m_p2pos = pos; end
          else begin m_p1 = 1; m_p1pos = pos; end
          m_chk = 1;
          m_cc  = 0;
        end
      end
      m_db1d = m_db1;
      m_db2d = m_db2;
      if (h1[D:1] == {D{!m_db1}}) m_db1 = !m_db1;
      if (h2[D:1] == {D{!m_db2}}) m_db2 = !m_db2;
      h1 = {h1[D-1:0], btn_p1};
      h2 = {h2[D-1:0], btn_p2};
      swh1 = swh0;
      swh0 = sw_pos;
    end
  end

  bit chk_en = 0;
  int cnt_p1, cnt_p2, cnt_rej;

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_p1", o_p1, m_p1);
      check("model_p2", o_p2, m_p2);
      check("model_p1_pos", o_p1_pos, m_p1pos);
      check("model_p2_pos", o_p2_pos, m_p2pos);
      check("model_turn", o_turn, m_turn);
      check("model_rejected", o_rejected, m_rej);
    end
    if (o_p1 === 1'b1) cnt_p1++;
    if (o_p2 === 1'b1) cnt_p2++;
    if (o_rejected === 1'b1) cnt_rej++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic zero_counts();
    cnt_p1 = 0; cnt_p2 = 0; cnt_rej = 0;
  endtask

  task automatic do_reset();
    reset = 1; btn_p1 = 0; btn_p2 = 0; illegal_move = 0; game_done = 0;
    repeat (3) tick();
    reset = 0;
    check("reset_outputs", {o_p1, o_p2, o_p1_pos, o_p2_pos, o_turn, o_rejected}, 0);
  endtask

  task automatic press(input bit p2sel, input int hold);
    if (p2sel) btn_p2 = 1; else btn_p1 = 1;
    repeat (hold) tick();
    if (p2sel) btn_p2 = 0; else btn_p1 = 0;
    repeat (hold) tick();
  endtask

  task automatic wait_strobe(input bit p2sel, input string name);
    bit seen = 0;
    for (int i = 0; i < 30 && !seen; i++) begin
      tick();
      if ((p2sel ? o_p2 : o_p1) === 1'b1) seen = 1;
    end
    check(name, seen, 1);
  endtask

  initial begin
    int seg1, seg2, rst_left;
    tick();
    chk_en = 1;

    // 1: exact latency
    sw_pos = 4'd2;
    do_reset();
    repeat (2) tick();
    btn_p1 = 1;
    for (int k = 0; k <= 8; k++) begin
      tick();
      check("t1_p1_latency", o_p1, (k == 6));
      if (k == 6) check("t1_p1_pos", o_p1_pos, 2);
      check("t1_turn", o_turn, (k >= 8));
    end
    btn_p1 = 0;
    repeat (10) tick();

    // 2: bouncing button
    do_reset();
    zero_counts();
    for (int i = 0; i < 20; i++) begin
      btn_p1 = i[1];
      tick();
    end
    btn_p1 = 0;
    repeat (12) tick();
    check("t2_no_strobe", cnt_p1, 0);
    check("t2_no_reject", cnt_rej, 0);
    check("t2_turn", o_turn, 0);

    // 3: wrong player, then out-of-range position
    sw_pos = 4'd0;
    do_reset();
    zero_counts();
    press(1, 10);
    check("t3_p2_reject", cnt_rej, 1);
    check("t3_no_p2", cnt_p2, 0);
    check("t3_p2_pos", o_p2_pos, 0);
    check("t3_turn", o_turn, 0);
    sw_pos = 4'd9;
    repeat (3) tick();
    zero_counts();
    press(0, 10);
    check("t3_pos9_reject", cnt_rej, 1);
    check("t3_pos9_no_p1", cnt_p1, 0);
    check("t3_p1_pos", o_p1_pos, 0);

    // 4: illegal move keeps the turn
    sw_pos = 4'd4;
    do_reset();
    repeat (3) tick();
    btn_p1 = 1;
    wait_strobe(0, "t4_wait_p1");
    illegal_move = 1;
    tick();
    illegal_move = 0;
    check("t4_p1_pos", o_p1_pos, 4);
    btn_p1 = 0;
    repeat (10) tick();
    check("t4_turn_held", o_turn, 0);
    sw_pos = 4'd5;
    repeat (3) tick();
    zero_counts();
    press(0, 10);
    check("t4_retry_strobe", cnt_p1, 1);
    check("t4_retry_pos", o_p1_pos, 5);
    check("t4_turn_after", o_turn, 1);

    // 5: simultaneous presses on P2's turn
    sw_pos = 4'd0;
    do_reset();
    repeat (3) tick();
    press(0, 10);
    check("t5_turn1", o_turn, 1);
    sw_pos = 4'd3;
    repeat (3) tick();
    zero_counts();
    btn_p1 = 1; btn_p2 = 1;
    repeat (12) tick();
    btn_p1 = 0; btn_p2 = 0;
    repeat (12) tick();
    check("t5_p2_once", cnt_p2, 1);
    check("t5_no_p1", cnt_p1, 0);
    check("t5_reject_once", cnt_rej, 1);
    check("t5_p2_pos", o_p2_pos, 3);

    // 6: game over during CHECK, then reset mid-debounce
    sw_pos = 4'd1;
    do_reset();
    repeat (3) tick();
    btn_p1 = 1;
    wait_strobe(0, "t6_wait_p1");
    game_done = 1;
    tick();
    btn_p1 = 0;
    repeat (10) tick();
    check("t6_turn_frozen", o_turn, 0);
    zero_counts();
    press(1, 10);
    press(0, 10);
    check("t6_over_rejects", cnt_rej, 2);
    check("t6_over_no_strobe", cnt_p1 + cnt_p2, 0);
    check("t6_over_turn", o_turn, 0);
    game_done = 0;
    btn_p2 = 1;
    repeat (3) tick();
    reset = 1;
    btn_p2 = 0;
    repeat (2) tick();
    check("t6_reset_outputs", {o_p1, o_p2, o_p1_pos, o_p2_pos, o_turn, o_rejected}, 0);
    reset = 0;
    zero_counts();
    repeat (20) tick();
    check("t6_no_strobe_after", cnt_p2 + cnt_p1, 0);
    check("t6_no_reject_after", cnt_rej, 0);
    check("t6_turn_after", o_turn, 0);

    // Randomized traffic, checked every cycle by the model
    do_reset();
    seg1 = 1; seg2 = 1; rst_left = 0;
    for (int i = 0; i < 4000; i++) begin
      if (--seg1 == 0) begin btn_p1 = ~btn_p1; seg1 = $urandom_range(1, 12); end
      if (--seg2 == 0) begin btn_p2 = ~btn_p2; seg2 = $urandom_range(1, 12); end
      if ($urandom_range(0, 19) == 0) sw_pos = 4'($urandom_range(0, 15));
      illegal_move = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 399) == 0) game_done = 1;
      if (rst_left > 0) rst_left--;
      else if ($urandom_range(0, 299) == 0) begin rst_left = 2; game_done = 0; end
      reset = (rst_left > 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
